cpu_axi_bridge: RTL and testbench

- Sits directly downstream of the CPU top. Converts its two sram-like ports (instruction fetch and data access) into one AXI3 master port.
- Provides the req/addr_ok/data_ok handshake that the pipeline stages use, so fetch and memory stages can stall on bus latency.
- Arbitrates read and write traffic and enforces ordering so a load never overtakes an outstanding store.

---
 rtl/cpu_axi_pkg.sv | 16 +
 rtl/axi_rd_arbiter.sv | 103 ++++++++++
 rtl/cpu_axi_bridge.sv | 169 ++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared types and constants for the CPU-to-AXI3 bridge
package cpu_axi_pkg;

    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_AW_W, WR_B} wr_state_e;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_e;

    localparam logic [3:0] AXI_INST_ID = 4'd0;
    localparam logic [3:0] AXI_DATA_ID = 4'd1;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - read channel FSM; arbitrates data loads over instruction fetches
module axi_rd_arbiter
    import cpu_axi_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [3:0] INST_ID = AXI_INST_ID,
    parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inst_req_i,
    input  logic [1:0]    inst_size_i,
    input  logic [AW-1:0] inst_addr_i,
    output logic          inst_addr_ok_o,
    output logic          inst_data_ok_o,
    output logic [DW-1:0] inst_rdata_o,
    input  logic          data_req_i,
    input  logic          data_wr_i,
    input  logic [1:0]    data_size_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic          wr_idle_i,
    output logic          load_addr_ok_o,
    output logic          load_data_ok_o,
    output logic [DW-1:0] load_rdata_o,
    output logic          data_rd_busy_o,
    output logic [3:0]    arid_o,
    output logic [AW-1:0] araddr_o,
    output logic [2:0]    arsize_o,
    output logic          arvalid_o,
    input  logic          arready_i,
    input  logic [3:0]    rid_i,
    input  logic [DW-1:0] rdata_i,
    input  logic          rvalid_i,
    output logic          rready_o
);

    rd_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic [3:0]    id_q, id_d;
    logic          load_ok, inst_ok, r_fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RD_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            id_q    <= id_d;
        end
    end

    // A load may only start once no store is pending, which keeps loads behind stores.
    always_comb begin
        load_ok = !rst_i && state_q == RD_IDLE && data_req_i && !data_wr_i && wr_idle_i;
        inst_ok = !rst_i && state_q == RD_IDLE && inst_req_i && !load_ok;
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        id_d    = id_q;
        case (state_q)
            RD_IDLE: begin
                if (load_ok) begin
                    addr_d  = data_addr_i;
                    size_d  = data_size_i;
                    id_d    = DATA_ID;
                    state_d = RD_AR;
                end else if (inst_ok) begin
                    addr_d  = inst_addr_i;
                    size_d  = inst_size_i;
                    id_d    = INST_ID;
                    state_d = RD_AR;
                end
            end
            RD_AR:   if (arready_i) state_d = RD_R;
            RD_R:    if (rvalid_i) state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        arvalid_o      = state_q == RD_AR;
        rready_o       = state_q == RD_R;
        r_fire         = rready_o && rvalid_i && !rst_i;
        inst_addr_ok_o = inst_ok;
        load_addr_ok_o = load_ok;
        inst_data_ok_o = r_fire && rid_i == INST_ID;
        load_data_ok_o = r_fire && rid_i != INST_ID;
        data_rd_busy_o = state_q != RD_IDLE && id_q != INST_ID;
    end

    assign arid_o       = id_q;
    assign araddr_o     = addr_q;
    assign arsize_o     = axi_size(size_q);
    assign inst_rdata_o = rdata_i;
    assign load_rdata_o = rdata_i;

endmodule

// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - sram-like inst/data ports to a single AXI3 master port
module cpu_axi_bridge
    import cpu_axi_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [3:0] INST_ID = AXI_INST_ID,
    parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_req,
    input  logic [1:0]    inst_size,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [3:0]    data_wstrb,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,
    output logic [3:0]    arid,
    output logic [AW-1:0] araddr,
    output logic [7:0]    arlen,
    output logic [2:0]    arsize,
    output logic [1:0]    arburst,
    output logic [1:0]    arlock,
    output logic [3:0]    arcache,
    output logic [2:0]    arprot,
    output logic          arvalid,
    input  logic          arready,
    input  logic [3:0]    rid,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp,
    input  logic          rlast,
    input  logic          rvalid,
    output logic          rready,
    output logic [3:0]    awid,
    output logic [AW-1:0] awaddr,
    output logic [7:0]    awlen,
    output logic [2:0]    awsize,
    output logic [1:0]    awburst,
    output logic [1:0]    awlock,
    output logic [3:0]    awcache,
    output logic [2:0]    awprot,
    output logic          awvalid,
    input  logic          awready,
    output logic [3:0]    wid,
    output logic [DW-1:0] wdata,
    output logic [3:0]    wstrb,
    output logic          wlast,
    output logic          wvalid,
    input  logic          wready,
    input  logic [3:0]    bid,
    input  logic [1:0]    bresp,
    input  logic          bvalid,
    output logic          bready
);

    wr_state_e     wr_q, wr_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [1:0]    wsize_q, wsize_d;
    logic          wr_idle, rd_data_busy, store_ok, b_fire;
    logic          load_addr_ok, load_data_ok;
    logic          unused_inputs;

    axi_rd_arbiter #(.AW(AW), .DW(DW), .INST_ID(INST_ID), .DATA_ID(DATA_ID)) u_rd (
        .clk_i(clk), .rst_i(reset),
        .inst_req_i(inst_req), .inst_size_i(inst_size), .inst_addr_i(inst_addr),
        .inst_addr_ok_o(inst_addr_ok), .inst_data_ok_o(inst_data_ok), .inst_rdata_o(inst_rdata),
        .data_req_i(data_req), .data_wr_i(data_wr), .data_size_i(data_size),
        .data_addr_i(data_addr), .wr_idle_i(wr_idle),
        .load_addr_ok_o(load_addr_ok), .load_data_ok_o(load_data_ok), .load_rdata_o(data_rdata),
        .data_rd_busy_o(rd_data_busy),
        .arid_o(arid), .araddr_o(araddr), .arsize_o(arsize), .arvalid_o(arvalid),
        .arready_i(arready), .rid_i(rid), .rdata_i(rdata), .rvalid_i(rvalid), .rready_o(rready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q      <= WR_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wsize_q   <= '0;
        end else begin
            wr_q      <= wr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wsize_q   <= wsize_d;
        end
    end

    // AW and W retire independently; the response phase starts once both are gone.
    always_comb begin
        store_ok  = !reset && wr_q == WR_IDLE && data_req && data_wr && !rd_data_busy;
        wr_d      = wr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wsize_d   = wsize_q;
        case (wr_q)
            WR_IDLE: begin
                if (store_ok) begin
                    awaddr_d  = data_addr;
                    wdata_d   = data_wdata;
                    wstrb_d   = data_wstrb;
                    wsize_d   = data_size;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wr_d      = WR_AW_W;
                end
            end
            WR_AW_W: begin
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!awvalid_d && !wvalid_d) wr_d = WR_B;
            end
            WR_B:    if (bvalid) wr_d = WR_IDLE;
            default: wr_d = WR_IDLE;
        endcase
    end

    always_comb begin
        wr_idle      = wr_q == WR_IDLE;
        bready       = wr_q == WR_B;
        b_fire       = bready && bvalid && !reset;
        data_addr_ok = load_addr_ok || store_ok;
        data_data_ok = load_data_ok || b_fire;
    end

    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;
    assign awaddr  = awaddr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign awsize  = axi_size(wsize_q);
    assign awid    = DATA_ID;
    assign wid     = DATA_ID;
    assign wlast   = 1'b1;
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = 2'd0;
    assign awlock  = 2'd0;
    assign arcache = 4'd0;
    assign awcache = 4'd0;
    assign arprot  = 3'd0;
    assign awprot  = 3'd0;

    assign unused_inputs = ^{rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb/tb_cpu_axi_bridge.sv - vector table, directed sequences and randomized traffic against a memory model
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    cpu_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_size = 2'd2; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    typedef struct {
        logic        inst_req, data_req, data_wr;
        logic [1:0]  size;
        logic [31:0] inst_addr, data_addr;
        logic        exp_iaok, exp_daok, exp_arvalid;
        logic [3:0]  exp_arid;
        logic [31:0] exp_araddr;
        logic [2:0]  exp_arsize;
        logic        exp_awvalid;
        logic [31:0] exp_awaddr;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] smem[128];
    logic [31:0] mmem[128];
    logic [31:0] iq[$];
    logic [32:0] dq[$];

    initial begin
        logic        i_acc, d_acc, ar_hs, r_hs, aw_hs, w_hs, b_hs, issue;
        logic        r_pend, aw_got, w_got;
        logic [6:0]  r_idx, aw_idx;
        logic [3:0]  r_id, w_strb;
        logic [31:0] w_data;
        logic [32:0] item;
        int          nstores;

        vecs[0] = '{1, 0, 0, 2'd2, 32'h1c000000, 32'h0,  1, 0, 1, 4'd0, 32'h1c000000, 3'd2, 0, 32'h0};
        vecs[1] = '{0, 1, 0, 2'd1, 32'h0, 32'h80,        0, 1, 1, 4'd1, 32'h80, 3'd1, 0, 32'h0};
        vecs[2] = '{1, 1, 0, 2'd2, 32'h1c000004, 32'h84, 0, 1, 1, 4'd1, 32'h84, 3'd2, 0, 32'h0};
        vecs[3] = '{0, 1, 1, 2'd0, 32'h0, 32'h88,        0, 1, 0, 4'd0, 32'h0, 3'd0, 1, 32'h88};
        vecs[4] = '{1, 1, 1, 2'd2, 32'h1c000008, 32'h8c, 1, 1, 1, 4'd0, 32'h1c000008, 3'd2, 1, 32'h8c};
        vecs[5] = '{0, 0, 0, 2'd2, 32'h1c00000c, 32'h90, 0, 0, 0, 4'd0, 32'h0, 3'd0, 0, 32'h0};

        // reset state, with requests pending
        idle_inputs();
        reset = 1; inst_req = 1; data_req = 1;
        step();
        @(negedge clk);
        chk("rst_addr_ok", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        chk("rst_regs", {araddr, awaddr, wdata, wstrb, arid}, 0);

        foreach (vecs[i]) begin
            do_reset();
            inst_req = vecs[i].inst_req; data_req = vecs[i].data_req; data_wr = vecs[i].data_wr;
            inst_size = vecs[i].size; data_size = vecs[i].size;
            inst_addr = vecs[i].inst_addr; data_addr = vecs[i].data_addr;
            @(negedge clk);
            chk($sformatf("v%0d_inst_aok", i), inst_addr_ok, vecs[i].exp_iaok);
            chk($sformatf("v%0d_data_aok", i), data_addr_ok, vecs[i].exp_daok);
            step();
            inst_req = 0; data_req = 0;
            @(negedge clk);
            chk($sformatf("v%0d_arvalid", i), arvalid, vecs[i].exp_arvalid);
            chk($sformatf("v%0d_arid", i), arid, vecs[i].exp_arid);
            chk($sformatf("v%0d_araddr", i), araddr, vecs[i].exp_araddr);
            chk($sformatf("v%0d_arsize", i), arsize, vecs[i].exp_arsize);
            chk($sformatf("v%0d_awvalid", i), {awvalid, wvalid}, {2{vecs[i].exp_awvalid}});
            chk($sformatf("v%0d_awaddr", i), awaddr, vecs[i].exp_awaddr);
        end

        // ideal-slave instruction read
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000000; arready = 1;
        @(negedge clk); chk("s1_aok_c0", inst_addr_ok, 1);
        step(); inst_req = 0;
        @(negedge clk);
        chk("s1_ar_c1", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h1c000000});
        chk("s1_ar_const", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
        step(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h02800000;
        @(negedge clk); chk("s1_dok_c2", {inst_data_ok, data_data_ok, inst_rdata}, {2'b10, 32'h02800000});
        step(); rvalid = 0;

        // load beats concurrent inst; inst issued after the load's rvalid
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000040; data_req = 1; data_addr = 32'h44;
        @(negedge clk); chk("s2_aok", {data_addr_ok, inst_addr_ok}, 2'b10);
        step(); data_req = 0; arready = 1;
        @(negedge clk); chk("s2_ar_data", {arvalid, arid, inst_addr_ok}, {1'b1, 4'd1, 1'b0});
        step(); arready = 0; rvalid = 1; rid = 1; rdata = 32'h55aa55aa;
        @(negedge clk); chk("s2_load_dok", {data_data_ok, inst_data_ok, inst_addr_ok, data_rdata}, {3'b100, 32'h55aa55aa});
        step(); rvalid = 0;
        @(negedge clk); chk("s2_inst_aok", inst_addr_ok, 1);
        step(); inst_req = 0;
        @(negedge clk); chk("s2_ar_inst", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h1c000040});

        // store with late awready, immediate wready
        do_reset();
        data_req = 1; data_wr = 1; data_addr = 32'h80; data_wstrb = 4'b0011;
        data_wdata = 32'h1234abcd; data_size = 2'd2; wready = 1;
        @(negedge clk); chk("s3_aok", data_addr_ok, 1);
        step(); data_req = 0;
        @(negedge clk);
        chk("s3_c1", {awvalid, wvalid, wstrb, wdata, awaddr}, {2'b11, 4'b0011, 32'h1234abcd, 32'h80});
        chk("s3_w_const", {wlast, wid, awid, awsize, awlen, awburst}, {1'b1, 4'd1, 4'd1, 3'd2, 8'd0, 2'b01});
        step();
        @(negedge clk); chk("s3_c2", {awvalid, wvalid}, 2'b10);
        step(); awready = 1;
        @(negedge clk); chk("s3_c3", {awvalid, wvalid, bready}, 3'b100);
        step(); awready = 0;
        @(negedge clk); chk("s3_c4", {awvalid, bready, data_data_ok}, 3'b010);
        step(); bvalid = 1;
        @(negedge clk); chk("s3_c5", data_data_ok, 1);
        step(); bvalid = 0;

        // load held off behind an outstanding store
        do_reset();
        data_req = 1; data_wr = 1; data_addr = 32'h80; data_wstrb = 4'hf; data_wdata = 32'hcafef00d;
        awready = 1; wready = 1;
        @(negedge clk); chk("s4_store_aok", data_addr_ok, 1);
        step(); data_wr = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); chk($sformatf("s4_hold_c%0d", c), data_addr_ok, 0);
            step();
        end
        bvalid = 1;
        @(negedge clk); chk("s4_b_cycle", {data_data_ok, data_addr_ok}, 2'b10);
        step(); bvalid = 0;
        @(negedge clk); chk("s4_load_aok", data_addr_ok, 1);
        step(); data_req = 0; arready = 1;
        @(negedge clk); chk("s4_ar", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h80});
        step(); arready = 0; rvalid = 1; rid = 1; rdata = 32'hcafef00d;
        @(negedge clk); chk("s4_rdata", {data_data_ok, data_rdata}, {1'b1, 32'hcafef00d});
        step(); rvalid = 0;

        // store accepted while an inst read sits in RD_R
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000010; arready = 1;
        @(negedge clk); chk("s5_inst_aok", inst_addr_ok, 1);
        step(); inst_req = 0;
        step(); arready = 0;
        data_req = 1; data_wr = 1; data_addr = 32'h90; data_wstrb = 4'hf; data_wdata = 32'hdeadbeef;
        awready = 1; wready = 1;
        @(negedge clk); chk("s5_store_aok", {rready, data_addr_ok}, 2'b11);
        step(); data_req = 0; rvalid = 1; rid = 0; rdata = 32'h11112222;
        @(negedge clk);
        chk("s5_inst_dok", {inst_data_ok, data_data_ok, inst_rdata}, {2'b10, 32'h11112222});
        step(); rvalid = 0; bvalid = 1;
        @(negedge clk); chk("s5_store_dok", {data_data_ok, inst_data_ok}, 2'b10);
        step(); bvalid = 0;

        // reset while arvalid is up
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000020;
        @(negedge clk); chk("s6_aok", inst_addr_ok, 1);
        step(); inst_addr = 32'h1c000030;
        @(negedge clk); chk("s6_arvalid", arvalid, 1);
        #2 reset = 1;
        #1 chk("s6_async_drop", {arvalid, inst_addr_ok}, 2'b00);
        step(); step(); reset = 0;
        @(negedge clk); chk("s6_after_rst_aok", inst_addr_ok, 1);
        step(); inst_req = 0;
        @(negedge clk); chk("s6_new_ar", {arvalid, araddr}, {1'b1, 32'h1c000030});

        // randomized traffic against a slave memory and an sram-port ordering model
        do_reset();
        for (int i = 0; i < 128; i++) begin
            smem[i] = $urandom;
            mmem[i] = smem[i];
        end
        r_pend = 0; aw_got = 0; w_got = 0; r_idx = 0; aw_idx = 0; r_id = 0; w_strb = 0; w_data = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            issue = cyc < 3000;
            @(negedge clk);
            if (inst_data_ok) begin
                chk("rnd_inst_expected", 64'(iq.size() > 0), 1);
                if (iq.size() > 0) chk("rnd_inst_rdata", inst_rdata, iq.pop_front());
            end
            if (data_data_ok) begin
                chk("rnd_data_expected", 64'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    item = dq.pop_front();
                    if (!item[32]) chk("rnd_load_rdata", data_rdata, item[31:0]);
                end
            end
            i_acc = inst_req && inst_addr_ok;
            d_acc = data_req && data_addr_ok;
            if (i_acc) iq.push_back(mmem[inst_addr[8:2]]);
            if (d_acc) begin
                if (data_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (data_wstrb[b]) mmem[data_addr[8:2]][8*b +: 8] = data_wdata[8*b +: 8];
                    dq.push_back({1'b1, 32'h0});
                end else begin
                    nstores = 0;
                    foreach (dq[k]) if (dq[k][32]) nstores++;
                    chk("rnd_load_after_store", 64'(nstores), 0);
                    dq.push_back({1'b0, mmem[data_addr[8:2]]});
                end
            end
            ar_hs = arvalid && arready; r_hs = rvalid && rready;
            aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;

            step();
            if (i_acc) inst_req = 0;
            if (!inst_req && issue && $urandom_range(0, 1) == 1) begin
                inst_req = 1;
                inst_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (d_acc) data_req = 0;
            if (!data_req && issue && $urandom_range(0, 1) == 1) begin
                data_req = 1;
                data_wr = 1'($urandom_range(0, 1));
                data_addr = 32'h100 + (32'($urandom_range(0, 7)) << 2);
                data_wstrb = 4'($urandom_range(1, 15));
                data_wdata = $urandom;
            end
            if (ar_hs) begin r_pend = 1; r_idx = araddr[8:2]; r_id = arid; end
            if (r_hs) rvalid = 0;
            if (!rvalid && r_pend && $urandom_range(0, 2) != 0) begin
                rvalid = 1; rid = r_id; rdata = smem[r_idx]; r_pend = 0;
            end
            if (aw_hs) begin aw_got = 1; aw_idx = awaddr[8:2]; end
            if (w_hs) begin w_got = 1; w_data = wdata; w_strb = wstrb; end
            if (b_hs) bvalid = 0;
            if (aw_got && w_got && !bvalid && $urandom_range(0, 2) != 0) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb[b]) smem[aw_idx][8*b +: 8] = w_data[8*b +: 8];
                bvalid = 1; aw_got = 0; w_got = 0;
            end
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready = 1'($urandom_range(0, 1));
        end
        chk("rnd_inst_drained", 64'(iq.size()), 0);
        chk("rnd_data_drained", 64'(dq.size()), 0);
        chk("rnd_ports_idle", {inst_req, data_req}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
